// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the PC-source and FSM state encodings plus the reset constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_REL = 2'b01,
    PCSRC_REG = 2'b10
  } pcsrc_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Encoding 2'b11 is reserved and behaves as sequential.
  function automatic logic is_redirect(input logic [1:0] pcsrc);
    return (pcsrc == PCSRC_REL) || (pcsrc == PCSRC_REG);
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential PCF+4 or a word-aligned redirect target
// taken from the PC-relative adder or the JALR ALU result.
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] pcf,
  input  logic [WIDTH-1:0] brpc,
  input  logic [WIDTH-1:0] immext,
  input  logic [WIDTH-1:0] jalr_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect
);

  logic [WIDTH-1:0] target;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    target   = jalr_target;
    redirect = is_redirect(pcsrc);
    case (pcsrc)
      PCSRC_REL: target = brpc + immext;
      PCSRC_REG: target = jalr_target;
      default:   target = jalr_target;
    endcase
    // Redirect targets are forced onto a word boundary; all sums wrap modulo 2^WIDTH.
    next_pc = redirect ? {target[WIDTH-1:2], 2'b00} : pcf + WIDTH'(4);
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding memory fetch FSM,
// one-entry skid buffer and the IF/ID pipeline register feeding decode.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] BrPC,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic [WIDTH-1:0] JalrTarget,
  input  logic             StallD,
  output logic             ImemReqValid,
  output logic [WIDTH-1:0] ImemAddr,
  input  logic             ImemReqReady,
  input  logic             ImemRspValid,
  input  logic [WIDTH-1:0] ImemRspData,
  output logic             ValidD,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D
);

  localparam logic [WIDTH-1:0] NOP  = WIDTH'(NOP_INSTR);
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  fetch_state_e     state, state_nxt;
  logic [WIDTH-1:0] pcf;
  logic [WIDTH-1:0] inflight_pc;
  logic [WIDTH-1:0] skid_instr;
  logic [WIDTH-1:0] skid_pc;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             req_accept;
  logic             ifid_free;
  logic             load_rsp;
  logic             park_rsp;
  logic             load_skid;

  pc_next_logic #(.WIDTH(WIDTH)) u_pc_next (
    .pcsrc       (PCSrc),
    .pcf         (pcf),
    .brpc        (BrPC),
    .immext      (ImmExt),
    .jalr_target (JalrTarget),
    .next_pc     (next_pc),
    .redirect    (redirect)
  );

  assign ImemReqValid = (state == REQ);
  assign ImemAddr     = pcf;

  // A redirect kills whatever the response or skid would have delivered.
  always_comb begin
    req_accept = (state == REQ) && ImemReqReady;
    ifid_free  = !ValidD || !StallD;
    load_rsp   = (state == WAIT) && ImemRspValid && ifid_free  && !redirect;
    park_rsp   = (state == WAIT) && ImemRspValid && !ifid_free && !redirect;
    load_skid  = (state == HOLD) && !StallD && !redirect;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (req_accept) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect)          state_nxt = ImemRspValid ? REQ : DROP;
        else if (ImemRspValid) state_nxt = ifid_free ? REQ : HOLD;
      end
      HOLD: begin
        if (redirect || !StallD) state_nxt = REQ;
      end
      // The stale response is swallowed here; a further redirect only moves PCF.
      DROP: begin
        if (ImemRspValid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and the skid data register is cleared with it so decode never sees X.
    if (!rst_n) begin
      state       <= IDLE;
      pcf         <= RESET_PC;
      inflight_pc <= RESET_PC;
      skid_instr  <= NOP;
      skid_pc     <= '0;
      ValidD      <= 1'b0;
      InstrD      <= NOP;
      PCD         <= '0;
      PCPlus4D    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      state <= state_nxt;

      if (redirect || req_accept) pcf <= next_pc;
      if (req_accept) inflight_pc <= pcf;

      if (redirect) begin
        skid_instr <= NOP;
        skid_pc    <= '0;
      end else if (park_rsp) begin
        skid_instr <= ImemRspData;
        skid_pc    <= inflight_pc;
      end

      if (redirect) begin
        ValidD <= 1'b0;
        InstrD <= NOP;
      end else if (load_rsp) begin
        ValidD   <= 1'b1;
        InstrD   <= ImemRspData;
        PCD      <= inflight_pc;
        PCPlus4D <= inflight_pc + FOUR;
      end else if (load_skid) begin
        ValidD   <= 1'b1;
        InstrD   <= skid_instr;
        PCD      <= skid_pc;
        PCPlus4D <= skid_pc + FOUR;
      end else if (!StallD) begin
        ValidD <= 1'b0;
        InstrD <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: memory model plus a queue-based
// scoreboard of the instructions decode should see, directed and random stimulus.
module tb_instr_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] BrPC, ImmExt, JalrTarget;
  logic        StallD;
  logic        ImemReqValid;
  logic [31:0] ImemAddr;
  logic        ImemReqReady, ImemRspValid;
  logic [31:0] ImemRspData;
  logic        ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D;

  instr_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .BrPC(BrPC), .ImmExt(ImmExt),
    .JalrTarget(JalrTarget), .StallD(StallD), .ImemReqValid(ImemReqValid),
    .ImemAddr(ImemAddr), .ImemReqReady(ImemReqReady), .ImemRspValid(ImemRspValid),
    .ImemRspData(ImemRspData), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } fetch_t;
  typedef struct {
    logic [1:0]  pcsrc;
    logic [31:0] br, imm, jalr;
    logic [31:0] exp_addr;
    logic        exp_req;
    logic        exp_valid_d;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_t      q[$];        // instructions decode must still receive, in order
  logic [31:0] acc_log[$];  // addresses of accepted requests

  // Stimulus knobs applied by cycle()
  logic        stall_v;
  logic [1:0]  pcsrc_v;
  logic [31:0] br_v, imm_v, jalr_v;
  int          ready_mode;  // 0 always ready, 1 never, 2 random
  int          delay_min, delay_max;

  // Memory and model state
  bit          mem_busy, mem_killed;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: check outputs, drive inputs for the coming edge, update model.
  task automatic cycle();
    bit          rsp_now, rsp_killed, redirect, acc;
    logic [31:0] target, rsp_addr;
    fetch_t      f;
    if (q.size() > 0) begin
      check("validd", 32'(ValidD), 1);
      check("instrd", InstrD, q[0].instr);
      check("pcd", PCD, q[0].pc);
      check("pcplus4d", PCPlus4D, q[0].pc + 32'd4);
    end else begin
      check("validd_empty", 32'(ValidD), 0);
      check("instrd_nop", InstrD, NOP);
    end
    if (ImemReqValid) begin
      check("one_outstanding", 32'(mem_busy), 0);
      check("imemaddr", ImemAddr, exp_pc);
    end

    rsp_now = 0; rsp_killed = 0; rsp_addr = '0;
    ImemRspValid = 1'b0;
    ImemRspData  = $urandom();
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp_now = 1; rsp_killed = mem_killed; rsp_addr = mem_addr; mem_busy = 0;
        ImemRspValid = 1'b1;
        ImemRspData  = mem_addr ^ KEY;
      end
    end

    StallD = stall_v; PCSrc = pcsrc_v; BrPC = br_v; ImmExt = imm_v; JalrTarget = jalr_v;
    case (ready_mode)
      0:       ImemReqReady = 1'b1;
      1:       ImemReqReady = 1'b0;
      default: ImemReqReady = ($urandom_range(9, 0) < 7);
    endcase

    redirect = (pcsrc_v == 2'b01) || (pcsrc_v == 2'b10);
    target   = (pcsrc_v == 2'b01) ? br_v + imm_v : jalr_v;
    target   = target & 32'hFFFF_FFFC;

    if (redirect) q.delete();
    else if (q.size() > 0 && !stall_v) q.delete(0);
    if (rsp_now && !rsp_killed && !redirect) begin
      f.pc = rsp_addr; f.instr = rsp_addr ^ KEY;
      q.push_back(f);
    end

    acc = ImemReqValid && ImemReqReady;
    if (acc) begin
      mem_busy = 1; mem_addr = exp_pc; mem_killed = redirect;
      mem_cnt  = $urandom_range(delay_max, delay_min);
      acc_log.push_back(ImemAddr);
    end else if (redirect && mem_busy) begin
      mem_killed = 1;
    end
    if (redirect) exp_pc = target;
    else if (acc) exp_pc = exp_pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; StallD = 1'b0; PCSrc = 2'b00; BrPC = '0; ImmExt = '0; JalrTarget = '0;
    ImemReqReady = 1'b0; ImemRspValid = 1'b0; ImemRspData = '0;
    @(negedge clk);
    check("rst_reqvalid", 32'(ImemReqValid), 0);
    check("rst_addr", ImemAddr, 32'h0);
    check("rst_validd", 32'(ValidD), 0);
    check("rst_instrd", InstrD, NOP);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcplus4d", PCPlus4D, 32'h0);
    @(negedge clk);
    q.delete(); mem_busy = 0; mem_killed = 0; exp_pc = 32'h0;
    stall_v = 1'b0; pcsrc_v = 2'b00;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] got_pc[$], got_in[$];
    int          n0;

    vecs[0] = '{2'b01, 32'h100, 32'hFFFF_FFF0, 32'h0, 32'h0000_00F0, 1'b1, 1'b0};
    vecs[1] = '{2'b10, 32'h0, 32'h0, 32'h0000_0203, 32'h0000_0200, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 32'h0, 32'h0, 32'h0000_0999, 32'h0000_0200, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 32'h400, 32'h4, 32'h0000_0800, 32'h0000_0200, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 32'hFFFF_FFF8, 32'h10, 32'h0, 32'h0000_0008, 1'b1, 1'b0};
    vecs[5] = '{2'b01, 32'h7, 32'h2, 32'h0, 32'h0000_0008, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 1'b0};

    stall_v = 0; pcsrc_v = 0; br_v = 0; imm_v = 0; jalr_v = 0;
    ready_mode = 0; delay_min = 1; delay_max = 1;
    do_reset();

    // Sequential stream from reset with a 1-cycle memory
    for (int i = 0; i < 30 && got_pc.size() < 3; i++) begin
      if (ValidD) begin got_pc.push_back(PCD); got_in.push_back(InstrD); end
      cycle();
    end
    check("t1_count", got_pc.size(), 3);
    if (got_pc.size() == 3) begin
      check("t1_pc0", got_pc[0], 32'h0);
      check("t1_pc1", got_pc[1], 32'h4);
      check("t1_pc2", got_pc[2], 32'h8);
      check("t1_in0", got_in[0], 32'hA5A5_0000);
      check("t1_in1", got_in[1], 32'hA5A5_0004);
    end

    // Stall while the next response arrives: skid then release
    do_reset();
    for (int i = 0; i < 20 && !(ValidD && PCD == 32'h4); i++) cycle();
    check("t2_reach_pc4", 32'(ValidD && PCD == 32'h4), 1);
    stall_v = 1;
    repeat (3) cycle();
    check("t2_hold_reqvalid", 32'(ImemReqValid), 0);
    check("t2_hold_pcd", PCD, 32'h4);
    stall_v = 0;
    cycle();
    check("t2_release_pcd", PCD, 32'h8);
    check("t2_release_validd", 32'(ValidD), 1);

    // PC-relative redirect in WAIT before the response, under stall
    delay_min = 3; delay_max = 3;
    for (int i = 0; i < 20 && !ValidD; i++) cycle();
    stall_v = 1;
    for (int i = 0; i < 20 && !(mem_busy && !mem_killed && !ImemReqValid && mem_cnt > 1); i++) cycle();
    check("t3_in_wait", 32'(mem_busy && !ImemReqValid), 1);
    pcsrc_v = 2'b01; br_v = 32'h100; imm_v = 32'hFFFF_FFF0;
    cycle();
    pcsrc_v = 2'b00; stall_v = 0;
    check("t3_flush_validd", 32'(ValidD), 0);
    for (int i = 0; i < 20 && !ImemReqValid; i++) cycle();
    check("t3_target_addr", ImemAddr, 32'h0000_00F0);

    // JALR redirect in the same cycle as the response
    delay_min = 1; delay_max = 1;
    for (int i = 0; i < 20 && !(mem_busy && !mem_killed && !ImemReqValid && mem_cnt == 1); i++) cycle();
    check("t4_in_wait", 32'(mem_busy && !ImemReqValid), 1);
    pcsrc_v = 2'b10; jalr_v = 32'h0000_0203;
    cycle();
    pcsrc_v = 2'b00;
    check("t4_flush_validd", 32'(ValidD), 0);
    for (int i = 0; i < 20 && !ImemReqValid; i++) cycle();
    check("t4_target_addr", ImemAddr, 32'h0000_0200);

    // Unaccepted request redirected in its second cycle
    ready_mode = 1;
    for (int i = 0; i < 20 && !ImemReqValid; i++) cycle();
    n0 = acc_log.size();
    cycle();
    pcsrc_v = 2'b10; jalr_v = 32'h0000_0040;
    cycle();
    pcsrc_v = 2'b00;
    cycle(); cycle();
    check("t5_no_accept", acc_log.size() - n0, 0);
    check("t5_addr", ImemAddr, 32'h0000_0040);
    ready_mode = 0;
    cycle();
    check("t5_one_accept", acc_log.size() - n0, 1);
    if (acc_log.size() > n0) check("t5_accept_addr", acc_log[n0], 32'h0000_0040);

    // Address wrap, then reset in the middle of a fetch
    pcsrc_v = 2'b10; jalr_v = 32'hFFFF_FFFC;
    cycle();
    pcsrc_v = 2'b00;
    for (int i = 0; i < 20 && !(ValidD && PCD == 32'hFFFF_FFFC); i++) cycle();
    check("t6_wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("t6_wrap_pcplus4", PCPlus4D, 32'h0);
    for (int i = 0; i < 20 && !ImemReqValid; i++) cycle();
    check("t6_wrap_addr", ImemAddr, 32'h0);
    for (int i = 0; i < 20 && !(mem_busy && !ImemReqValid); i++) cycle();
    check("t6_in_wait", 32'(mem_busy && !ImemReqValid), 1);
    do_reset();

    // Randomized traffic against the scoreboard
    ready_mode = 2; delay_min = 1; delay_max = 3;
    for (int i = 0; i < 3000; i++) begin
      stall_v = ($urandom_range(9, 0) < 3);
      pcsrc_v = ($urandom_range(19, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      br_v = $urandom(); imm_v = $urandom(); jalr_v = $urandom();
      cycle();
    end
    stall_v = 0; pcsrc_v = 2'b00;
    repeat (20) cycle();

    // Redirect target table, memory never ready
    ready_mode = 1;
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 20 && !ImemReqValid; i++) cycle();
      pcsrc_v = vecs[r].pcsrc; br_v = vecs[r].br; imm_v = vecs[r].imm; jalr_v = vecs[r].jalr;
      cycle();
      pcsrc_v = 2'b00;
      check($sformatf("tbl%0d_addr", r), ImemAddr, vecs[r].exp_addr);
      check($sformatf("tbl%0d_req", r), 32'(ImemReqValid), 32'(vecs[r].exp_req));
      check($sformatf("tbl%0d_validd", r), 32'(ValidD), 32'(vecs[r].exp_valid_d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
